// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered owner index and a one-hot grant decode.
// Define RR_ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles (pulses tmo).
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       tmo
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] idx_reg, idx_next;
    logic [1:0] last_reg, last_next;
    logic [3:0] gnt_reg, gnt_next;
    logic [2:0] win;          // {found, index}
    logic       win_valid;
    logic [1:0] win_idx;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD must be in 1..255");
    end

    // First asserted request in the order base+1, base+2, base+3, base.
    function automatic logic [2:0] pick(input logic [1:0] base, input logic [3:0] r);
        logic [1:0] cand;
        pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = base + 2'(k);
            if (r[cand]) begin
                pick = {1'b1, cand};
            end
        end
    endfunction

    // last equals the current owner during GRANT, so one search serves every case.
    assign win       = pick(last_reg, req);
    assign win_valid = win[2];
    assign win_idx   = win[1:0];

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_reg, hold_cnt_next;
    logic       hold_expired;
    logic       tmo_reg, tmo_next;

    assign hold_expired = (state_reg == GRANT) && (hold_cnt_reg == HOLD_LAST);
    assign tmo_next     = hold_expired && req[idx_reg];
    // Counter only advances while the same grant continues; any new grant restarts it.
    assign hold_cnt_next = ((state_reg == GRANT) && req[idx_reg] && !hold_expired)
                           ? hold_cnt_reg + 8'd1 : 8'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt_reg <= 8'd0;
            tmo_reg      <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            tmo_reg      <= tmo_next;
        end
    end

    assign tmo = tmo_reg;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    state_next = GRANT;
                    idx_next   = win_idx;
                    last_next  = win_idx;
                end
            end
            GRANT: begin
                if (!req[idx_reg]) begin
                    if (win_valid) begin
                        idx_next  = win_idx;
                        last_next = win_idx;
                    end else begin
                        state_next = IDLE;
                    end
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (hold_expired) begin
                    // Owner still requesting, so win_valid holds; it wins only if alone.
                    idx_next  = win_idx;
                    last_next = win_idx;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_decode
        assign gnt_next[gi] = (state_next == GRANT) && (idx_next == 2'(gi));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            last_reg  <= 2'd3;
            gnt_reg   <= 4'b0000;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            last_reg  <= last_next;
            gnt_reg   <= gnt_next;
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_idx = idx_reg;
    assign busy    = (state_reg == GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed test-plan steps then randomized requests
// against a round-robin reference model; timeout behaviour follows RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter4;

    localparam int MAXH = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] req  = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       tmo;

    int total  = 0;
    int passed = 0;

    // Reference model: who owns the resource, how many cycles it has held it.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_held;
    bit m_tmo;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .tmo     (tmo)
    );

    function automatic int first_after(int base, logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = 3;
        m_held  = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_grant(int w);
        m_busy  = 1'b1;
        m_owner = w;
        m_last  = w;
        m_held  = 1;
    endtask

    task automatic model_edge(logic [3:0] r);
        int w;
        m_tmo = 1'b0;
        if (!m_busy) begin
            w = first_after(m_last, r);
            if (w >= 0) model_grant(w);
        end else if (!r[m_owner]) begin
            w = first_after(m_owner, r);
            if (w >= 0) model_grant(w);
            else m_busy = 1'b0;
        end else if (TMO_EN && m_held == MAXH) begin
            m_tmo = 1'b1;
            model_grant(first_after(m_owner, r));
        end else begin
            m_held++;
        end
    endtask

    task automatic check(string tag);
        logic [3:0] exp_gnt;
        exp_gnt = m_busy ? 4'(1 << m_owner) : 4'b0000;
        $display("[%0t] %s req=%b gnt=%b idx=%0d busy=%b tmo=%b", $time, tag, req, gnt, gnt_idx, busy, tmo);
        total++;
        assert (gnt === exp_gnt) passed++;
        else $error("FAIL %s gnt: got %b want %b", tag, gnt, exp_gnt);
        total++;
        assert (busy === m_busy) passed++;
        else $error("FAIL %s busy: got %b want %b", tag, busy, m_busy);
        total++;
        assert (tmo === m_tmo) passed++;
        else $error("FAIL %s tmo: got %b want %b", tag, tmo, m_tmo);
        if (m_busy) begin
            total++;
            assert (gnt_idx === 2'(m_owner)) passed++;
            else $error("FAIL %s gnt_idx: got %0d want %0d", tag, gnt_idx, m_owner);
        end
    endtask

    task automatic cycle(logic [3:0] r, string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check(tag);
    endtask

    task automatic async_reset(string tag);
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        check(tag);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        model_reset();
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("reset");
        rstn = 1'b1;

        // Rotation with everyone requesting, release-driven handoffs.
        cycle(4'b1111, "rot0");
        cycle(4'b1110, "rot1");
        cycle(4'b1101, "rot2");
        cycle(4'b1011, "rot3");
        cycle(4'b0111, "rot4");
        cycle(4'b0000, "rot_idle");
        cycle(4'b0000, "idle");

        // Single requester holding for five cycles.
        repeat (5) cycle(4'b0100, "hold2");
        cycle(4'b0000, "hold_rel");
        cycle(4'b0000, "hold_idle");

        // Requester 3 pulses while 1 owns; it must never be granted.
        cycle(4'b0010, "own1");
        cycle(4'b1010, "req3_up");
        cycle(4'b0010, "req3_down");
        cycle(4'b0010, "own1_hold");
        cycle(4'b0000, "own1_rel");

        // Asynchronous reset between edges while a grant is active.
        cycle(4'b0101, "pre_rst");
        cycle(4'b0101, "pre_rst_hold");
        req = 4'b1010;
        async_reset("async_rst");
        cycle(4'b1010, "post_rst");
        cycle(4'b1000, "post_rst_rel");
        cycle(4'b0000, "post_rst_idle");

        // Two contenders held forever, then a lone holder.
        repeat (12) cycle(4'b0011, "pair");
        cycle(4'b0000, "pair_rel");
        repeat (10) cycle(4'b0001, "lone0");
        cycle(4'b0000, "lone_rel");

        // Randomized requests with persistence; one reset in the middle.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            r = r ^ (4'($urandom) & 4'($urandom));
            cycle(r, "rand");
            if (i == 200) begin
                async_reset("rand_rst");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one resource selected through a 2-to-4 one-hot decode. The arbiter registers a 2-bit owner index and decodes it into a one-hot grant vector. Requesters raise `req[i]` and hold it for as long as they use the resource. The arbiter rotates priority so that no requester starves. It sits between the requesting units and the shared datapath, and drives both the select index and the decoded enables.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum grant length in cycles when the timeout feature is compiled in. Legal range is 1..255.

Ports:
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous reset, active-low.
- `req`  in  4  request vector. `req[i]` is level, held high while requester i wants or uses the resource.
- `gnt`  out  4  one-hot grant, the registered decode of `gnt_idx`. All zero when idle.
- `gnt_idx`  out  2  index of the current owner. Valid only while `busy`=1.
- `busy`  out  1  high while any grant is active.
- `tmo`  out  1  one-cycle pulse when a grant is revoked by timeout. Constant 0 without the macro.

## Operation
- State machine with two states, IDLE and GRANT. Reset enters IDLE.
- Internal `last[1:0]` holds the most recent owner. It resets to 3, so requester 0 has first priority after reset.
- Search order is last+1, last+2, last+3, last, each taken mod 4. The first asserted `req` in that order wins.
- IDLE:
  - `req`=0: stay in IDLE.
  - Otherwise: load winner into `gnt_idx` and `last`, set `busy`=1, go to GRANT.
- GRANT: the owner keeps the grant while `req[gnt_idx]`=1. Other requests are ignored.
- Release occurs when `req[gnt_idx]`=0 at a clock edge.
  - Release with other requests pending: hand off directly to the next winner on the same edge, with no idle cycle. `last` takes the released owner before the search runs.
  - Release with nothing pending: go to IDLE and set `gnt`=0, `busy`=0. `gnt_idx` holds its old value, which is don't-care.
- `gnt` always equals decode(`gnt_idx`) AND `busy`: 0001, 0010, 0100 or 1000. `gnt` never has more than one bit set.
- A requester may drop `req` before it is granted. It is simply never chosen.
- Simultaneous requests: the search order resolves them, so all four pending means the grant order rotates 0, 1, 2, 3, 0, ...
- Reset mid-grant: all outputs clear immediately, without waiting for a clock. `last` returns to 3 and the counter clears.

## Timing
- Reset values: `gnt`=0000, `gnt_idx`=00, `busy`=0, `tmo`=0. Internally `last`=3 and the counter is 0.
- Grant latency: `req` sampled high at edge N while IDLE gives `gnt` high after edge N, i.e. one cycle.
- Release latency: `req[owner]` sampled low at edge N. The handoff or return to IDLE is visible after edge N.
- The minimum grant length is therefore one cycle.
- All outputs are registered. There is no combinational path from `req` to `gnt`.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each cycle in GRANT.
  - When the counter reaches `MAX_HOLD`-1 with `req[owner]` still high, the next edge revokes the grant as a forced release and pulses `tmo`=1 for one cycle.
  - After revocation, the next winner is chosen with the revoked owner lowest in the search order.
  - If the revoked owner is the only requester, it is re-granted on the same edge with the counter cleared.
- Undefined: there is no counter, `tmo` is tied 0, and a grant lasts until the owner releases it.

## Test plan
- Reset with `req`=1111 held, then deassert `rstn` -> one cycle later `gnt`=0001. Releasing each owner in turn produces 0010, 0100, 1000, 0001 with no idle cycles between them.
- `req`=0100 alone for 5 cycles, then 0000 -> `gnt`=0100 for exactly 5 cycles, then `busy`=0 and `gnt`=0000.
- Owner 1 holds while `req[3]` rises and falls before the release -> requester 3 is never granted; `gnt` goes 0010 then 0000.
- Assert `rstn`=0 asynchronously mid-grant, between edges -> `gnt`=0000 and `busy`=0 immediately. After reset, `req`=1010 grants requester 1 first.
- Compile with `RR_ARB_TIMEOUT_EN` and `MAX_HOLD`=4; `req`=0011 with both held -> `gnt`=0001 for 4 cycles, `tmo` pulses, then `gnt`=0010 for 4 cycles, and the pattern alternates.
- Same build, `req`=0001 only -> `tmo` pulses every 4 cycles and `gnt` stays 0001 continuously.
